// File: rtl/dmglcd_pkg.sv
// rtl/dmglcd_pkg.sv - shared types and constants for the DMG LCD capture block
// Purpose: default panel geometry, capture state encoding and pixel type.
// Ports: none (package).
package dmglcd_pkg;

  localparam int LCD_WIDTH         = 160;
  localparam int LCD_HEIGHT        = 144;
  localparam int FB_BYTES_PER_LINE = LCD_WIDTH / 4;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2
  } cap_state_e;

  typedef logic [1:0] pixel_t;

endpackage

// File: rtl/dmglcd_capture_if.sv
// rtl/dmglcd_capture_if.sv - pixel, line/frame strobe and packed-write bus
// Purpose: groups the capture output stream so sinks connect with one port.
// Ports: master = capture side (drives everything), slave = framebuffer/debug sink.
interface dmglcd_capture_if;

  logic        px_valid;
  logic [7:0]  px_x;
  logic [7:0]  px_y;
  logic [1:0]  px_data;
  logic        line_done;
  logic        frame_start;
  logic        frame_done;
  logic        fb_we;
  logic [12:0] fb_addr;
  logic [7:0]  fb_wdata;

  modport master (
    output px_valid, px_x, px_y, px_data,
    output line_done, frame_start, frame_done,
    output fb_we, fb_addr, fb_wdata
  );

  modport slave (
    input px_valid, px_x, px_y, px_data,
    input line_done, frame_start, frame_done,
    input fb_we, fb_addr, fb_wdata
  );

endinterface

// File: rtl/dmglcd_sync.sv
// rtl/dmglcd_sync.sv - N-stage synchronizer with previous-value register
// Purpose: brings a bundle of async pins into clk16m; q_prev is q delayed one
//   clock so callers can detect edges.
// Ports: clk16m, rst_n (sync, active-low), d (async bundle), q (synced),
//   q_prev (q one clock earlier).
module dmglcd_sync #(
  parameter int STAGES = 2,
  parameter int W      = 1
) (
  input  logic         clk16m,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] q_prev
);

  if (STAGES < 2) begin : g_stage_chk
    $error("dmglcd_sync: STAGES must be at least 2");
  end

  logic [W-1:0] stg [STAGES];

  always_ff @(posedge clk16m) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stg[i] <= '0;
      q_prev <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
      q_prev <= stg[STAGES-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/dmglcd_capture.sv
// rtl/dmglcd_capture.sv - DMG LCD pin capture with pixel coordinate reconstruction
// Purpose: passively samples the LCD header, tracks line/frame position and
//   emits one strobe per pixel plus line/frame pulses and sticky error flags.
// Ports: clk16m, rst_n (sync, active-low); lcd_d/clk/hsync/vsync/latch/pol/tim
//   raw async pins (pol/tim unused); err_clr clears sticky errors;
//   px (master) pixel stream, strobes and packed writes; locked while
//   tracking a frame; err_short/err_long/err_lines sticky protocol errors.
// Optional: define DMGCAP_PACK_EN to pack 4 pixels per byte on px.fb_*.
module dmglcd_capture
  import dmglcd_pkg::*;
#(
  parameter int WIDTH       = LCD_WIDTH,
  parameter int HEIGHT      = LCD_HEIGHT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk16m,
  input  logic             rst_n,
  input  logic [1:0]       lcd_d,
  input  logic             lcd_clk,
  input  logic             lcd_hsync,
  input  logic             lcd_vsync,
  input  logic             lcd_latch,
  input  logic             lcd_pol,
  input  logic             lcd_tim,
  input  logic             err_clr,
  dmglcd_capture_if.master px,
  output logic             locked,
  output logic             err_short,
  output logic             err_long,
  output logic             err_lines
);

  localparam logic [7:0] X_END  = 8'(WIDTH);
  localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);

  // Data, syncs and clock share one bundle so d is sampled in the same stage
  // as the pclk level that produced the falling edge.
  logic [4:0] pin_q, pin_prev;
  logic [2:0] ctl_q, ctl_prev;

  dmglcd_sync #(.STAGES(SYNC_STAGES), .W(5)) u_sync_pix (
    .clk16m (clk16m),
    .rst_n  (rst_n),
    .d      ({lcd_vsync, lcd_hsync, lcd_d, lcd_clk}),
    .q      (pin_q),
    .q_prev (pin_prev)
  );

  dmglcd_sync #(.STAGES(SYNC_STAGES), .W(3)) u_sync_ctl (
    .clk16m (clk16m),
    .rst_n  (rst_n),
    .d      ({lcd_tim, lcd_pol, lcd_latch}),
    .q      (ctl_q),
    .q_prev (ctl_prev)
  );

  logic   clk_s, hsync_s, vsync_s;
  pixel_t d_s;
  logic   pclk_fall, latch_rise, marker, pixel;

  assign clk_s      = pin_q[0];
  assign d_s        = pin_q[2:1];
  assign hsync_s    = pin_q[3];
  assign vsync_s    = pin_q[4];
  assign pclk_fall  = pin_prev[0] & ~clk_s;
  assign latch_rise = ctl_q[0] & ~ctl_prev[0];
  assign marker     = pclk_fall & hsync_s;
  assign pixel      = pclk_fall & ~hsync_s;

  wire unused_sync = &{1'b0, pin_prev[4:1], ctl_q[2:1], ctl_prev[2:1]};

  cap_state_e state, state_d, eff;
  logic [7:0] x, x_d, y, y_d;
  logic       locked_d;
  logic       px_valid_q, px_valid_d;
  logic [7:0] px_x_q, px_x_d, px_y_q, px_y_d;
  pixel_t     px_data_q, px_data_d;
  logic       line_done_q, line_done_d;
  logic       frame_start_q, frame_start_d;
  logic       frame_done_q, frame_done_d;
  logic       set_short, set_long, set_lines;

  always_comb begin
    state_d       = state;
    eff           = state;
    x_d           = x;
    y_d           = y;
    locked_d      = locked;
    px_valid_d    = 1'b0;
    px_x_d        = px_x_q;
    px_y_d        = px_y_q;
    px_data_d     = px_data_q;
    line_done_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    set_short     = 1'b0;
    set_long      = 1'b0;
    set_lines     = 1'b0;

    // Line end first: an explicit latch, or a marker arriving while a line is
    // still open. The same-cycle marker/pixel is then handled as from ARMED.
    if (state == ACTIVE && (latch_rise || marker)) begin
      line_done_d = 1'b1;
      if (x < X_END) set_short = 1'b1;
      if (y == Y_LAST) frame_done_d = 1'b1;
      eff = ARMED;
    end
    state_d = eff;

    if (marker) begin
      if (eff == HUNT) begin
        if (vsync_s) begin
          x_d           = '0;
          y_d           = '0;
          frame_start_d = 1'b1;
          locked_d      = 1'b1;
          state_d       = ACTIVE;
        end
      end else begin
        x_d = '0;
        if (vsync_s) begin
          y_d           = '0;
          frame_start_d = 1'b1;
          state_d       = ACTIVE;
        end else if (y < Y_LAST) begin
          y_d     = y + 8'd1;
          state_d = ACTIVE;
        end else begin
          set_lines = 1'b1;
          locked_d  = 1'b0;
          state_d   = HUNT;
        end
      end
    end else if (pixel && eff == ACTIVE) begin
      if (x < X_END) begin
        px_valid_d = 1'b1;
        px_x_d     = x;
        px_y_d     = y;
        px_data_d  = d_s;
        x_d        = x + 8'd1;
      end else begin
        set_long = 1'b1;
      end
    end
  end

  always_ff @(posedge clk16m) begin
    if (!rst_n) begin
      state         <= HUNT;
      x             <= '0;
      y             <= '0;
      locked        <= 1'b0;
      px_valid_q    <= 1'b0;
      px_x_q        <= '0;
      px_y_q        <= '0;
      px_data_q     <= '0;
      line_done_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      err_short     <= 1'b0;
      err_long      <= 1'b0;
      err_lines     <= 1'b0;
    end else begin
      state         <= state_d;
      x             <= x_d;
      y             <= y_d;
      locked        <= locked_d;
      px_valid_q    <= px_valid_d;
      px_x_q        <= px_x_d;
      px_y_q        <= px_y_d;
      px_data_q     <= px_data_d;
      line_done_q   <= line_done_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      // A new error wins over a same-cycle clear.
      err_short     <= set_short | (err_short & ~err_clr);
      err_long      <= set_long  | (err_long  & ~err_clr);
      err_lines     <= set_lines | (err_lines & ~err_clr);
    end
  end

  assign px.px_valid    = px_valid_q;
  assign px.px_x        = px_x_q;
  assign px.px_y        = px_y_q;
  assign px.px_data     = px_data_q;
  assign px.line_done   = line_done_q;
  assign px.frame_start = frame_start_q;
  assign px.frame_done  = frame_done_q;

`ifdef DMGCAP_PACK_EN
  if ((WIDTH % 4) != 0) begin : g_width_chk
    $error("dmglcd_capture: WIDTH must be a multiple of 4 for packing");
  end

  localparam logic [12:0] BPL = 13'(WIDTH / 4);

  // Slots 0..2 of the byte in progress; slot 3 comes straight from d_s.
  logic [5:0]  pack_q;
  logic        fb_we_q;
  logic [12:0] fb_addr_q;
  logic [7:0]  fb_wdata_q;

  always_ff @(posedge clk16m) begin
    if (!rst_n) begin
      pack_q     <= '0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_wdata_q <= '0;
    end else begin
      fb_we_q <= 1'b0;
      if (px_valid_d) begin
        case (x[1:0])
          2'd0: pack_q[1:0] <= d_s;
          2'd1: pack_q[3:2] <= d_s;
          2'd2: pack_q[5:4] <= d_s;
          2'd3: begin
            fb_we_q    <= 1'b1;
            fb_addr_q  <= {5'd0, y} * BPL + {7'd0, x[7:2]};
            fb_wdata_q <= {d_s, pack_q};
          end
        endcase
      end
    end
  end

  assign px.fb_we    = fb_we_q;
  assign px.fb_addr  = fb_addr_q;
  assign px.fb_wdata = fb_wdata_q;
`else
  assign px.fb_we    = 1'b0;
  assign px.fb_addr  = '0;
  assign px.fb_wdata = '0;
`endif

endmodule
